axi_read_arbiter_2: RTL

- Shares one AXI4 read-address/read-data channel pair between two read-only requesters: slot 0 is the program-memory cache refill port, slot 1 is the LSU read path.
- Sits between those requesters and the single global-memory AXI master port of the processor.
- Allows one outstanding burst at a time. Round-robin grant with an registered FSM.
- Checks that the beat count matches ARLEN and flags a sticky protocol error.

---
 rtl/axi_read_arbiter_2_if.sv | 27 ++
 rtl/axi_read_arbiter_2.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/axi_read_arbiter_2_if.sv
// AXI4 read-address / read-data channel pair used on every side of axi_read_arbiter_2.
// master: issues addresses and accepts data; slave: accepts addresses and returns data.
interface axi_read_arbiter_2_if #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64,
  parameter int LEN_WIDTH  = 8
) ();
  logic [ADDR_WIDTH-1:0] araddr;
  logic [LEN_WIDTH-1:0]  arlen;
  logic                  arvalid;
  logic                  arready;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rlast;
  logic                  rvalid;
  logic                  rready;

  modport master (
    output araddr, arlen, arvalid, rready,
    input  arready, rdata, rresp, rlast, rvalid
  );

  modport slave (
    input  araddr, arlen, arvalid, rready,
    output arready, rdata, rresp, rlast, rvalid
  );
endinterface

// File: rtl/axi_read_arbiter_2.sv
// Two-requester AXI4 read arbiter, one outstanding burst, beat-count check against ARLEN.
// Define AXI_ARB_FIXED_PRIO_EN to make requester 0 always win instead of round-robin.
module axi_read_arbiter_2 #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                 clock,
  input  logic                 rst,
  axi_read_arbiter_2_if.slave  s0,
  axi_read_arbiter_2_if.slave  s1,
  axi_read_arbiter_2_if.master m,
  output logic                 busy,
  output logic                 protocol_err
);
  typedef enum logic [1:0] {IDLE = 2'd0, ADDR = 2'd1, DATA = 2'd2} state_t;

  state_t                state_reg, state_next;
  logic                  grant_reg, grant_next;
  logic [LEN_WIDTH-1:0]  beat_cnt_reg, beat_cnt_next;
  logic [LEN_WIDTH-1:0]  len_q_reg, len_q_next;
  logic                  protocol_err_reg, protocol_err_next;

  logic [1:0]            arvalid_v, rready_v, arready_v, rvalid_v;
  logic [ADDR_WIDTH-1:0] araddr_v [2];
  logic [LEN_WIDTH-1:0]  arlen_v [2];
  logic [DATA_WIDTH-1:0] rdata_w;
  logic                  win, beat, len_bad;

  assign arvalid_v  = {s1.arvalid, s0.arvalid};
  assign rready_v   = {s1.rready, s0.rready};
  assign araddr_v[0] = s0.araddr;
  assign araddr_v[1] = s1.araddr;
  assign arlen_v[0]  = s0.arlen;
  assign arlen_v[1]  = s1.arlen;

  assign beat    = (state_reg == DATA) && m.rvalid && rready_v[grant_reg];
  // Mismatch: rlast early/late relative to the count of beats seen so far.
  assign len_bad = m.rlast ? (beat_cnt_reg != len_q_reg) : (beat_cnt_reg == len_q_reg);

`ifdef AXI_ARB_FIXED_PRIO_EN
  assign win = ~arvalid_v[0];
`else
  logic rr_ptr_reg, rr_ptr_next;

  assign win = (arvalid_v == 2'b11) ? rr_ptr_reg : arvalid_v[1];

  always_comb begin
    rr_ptr_next = rr_ptr_reg;
    if (beat && m.rlast) rr_ptr_next = ~grant_reg;
  end

  always_ff @(posedge clock) begin
    if (rst) rr_ptr_reg <= 1'b0;
    else     rr_ptr_reg <= rr_ptr_next;
  end
`endif

  always_ff @(posedge clock) begin
    if (rst) begin
      state_reg        <= IDLE;
      grant_reg        <= 1'b0;
      beat_cnt_reg     <= '0;
      len_q_reg        <= '0;
      protocol_err_reg <= 1'b0;
    end else begin
      state_reg        <= state_next;
      grant_reg        <= grant_next;
      beat_cnt_reg     <= beat_cnt_next;
      len_q_reg        <= len_q_next;
      protocol_err_reg <= protocol_err_next;
    end
  end

  always_comb begin
    state_next        = state_reg;
    grant_next        = grant_reg;
    beat_cnt_next     = beat_cnt_reg;
    len_q_next        = len_q_reg;
    protocol_err_next = protocol_err_reg;
    case (state_reg)
      IDLE: begin
        if (|arvalid_v) begin
          grant_next    = win;
          beat_cnt_next = '0;
          state_next    = ADDR;
        end
      end
      ADDR: begin
        if (arvalid_v[grant_reg] && m.arready) begin
          len_q_next = arlen_v[grant_reg];
          state_next = DATA;
        end
      end
      DATA: begin
        if (beat) begin
          beat_cnt_next = beat_cnt_reg + 1'b1;
          if (len_bad) protocol_err_next = 1'b1;
          if (m.rlast) state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    m.araddr  = araddr_v[grant_reg];
    m.arlen   = arlen_v[grant_reg];
    m.arvalid = 1'b0;
    m.rready  = 1'b0;
    arready_v = '0;
    rvalid_v  = '0;
    case (state_reg)
      ADDR: begin
        m.arvalid            = arvalid_v[grant_reg];
        arready_v[grant_reg] = m.arready;
      end
      DATA: begin
        m.rready            = rready_v[grant_reg];
        rvalid_v[grant_reg] = m.rvalid;
      end
      default: ;
    endcase
  end

  // Data fields fan out to both requesters; only rvalid qualifies the owner.
  assign rdata_w    = m.rdata;
  assign s0.rdata   = rdata_w;
  assign s1.rdata   = rdata_w;
  assign s0.rresp   = m.rresp;
  assign s1.rresp   = m.rresp;
  assign s0.rlast   = m.rlast;
  assign s1.rlast   = m.rlast;
  assign s0.arready = arready_v[0];
  assign s1.arready = arready_v[1];
  assign s0.rvalid  = rvalid_v[0];
  assign s1.rvalid  = rvalid_v[1];

  assign busy         = (state_reg != IDLE);
  assign protocol_err = protocol_err_reg;
endmodule
